seq_detect_param: RTL and testbench

- Parametrised serial sequence detector: the generalised successor to the team's fixed 2-bit-state detectors.
- Samples one bit per enabled clock from a serial input and compares the last LEN samples against a compile-time PATTERN.
- On a match, emits a one-cycle registered pulse and increments a saturating match counter.
- Overlapping or non-overlapping detection is selected by parameter; sits between a serial bit source and control/status logic.

---
 rtl/seq_detect_param.sv | 66 ++++++
 tb/tb_seq_detect_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: matches the last LEN enabled samples of x
// against PATTERN, pulses y one cycle later and keeps a saturating match count.
module seq_detect_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int             FW      = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FULL    = FW'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LEN-1:0] hist, hist_n;
    logic [FW-1:0]  fill, fill_n;
    logic           match;

    // fill gates the compare so reset zeros never alias an all-zero pattern
    always_comb begin
        hist_n = {hist[LEN-2:0], x};
        fill_n = (fill == FULL) ? fill : fill + 1'b1;
        match  = en && (fill_n == FULL) && (hist_n == PATTERN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else begin
            y <= match;
            if (en) begin
                if (match && !OVERLAP) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= hist_n;
                    fill <= fill_n;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (match && match_cnt != CNT_MAX) begin
            match_cnt <= match_cnt + 1'b1;
            cnt_sat   <= (match_cnt + 1'b1 == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: four configurations share one stimulus
// stream; a bit-list reference model predicts y/count/sat for each every cycle.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, x = 1'b0, cnt_clr = 1'b0;

    logic       y0, y1, y2, y3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic       s0, s1, s2, s3;

    always #5 clk = ~clk;

    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr), .y(y0), .match_cnt(c0), .cnt_sat(s0));
    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr), .y(y1), .match_cnt(c1), .cnt_sat(s1));
    seq_detect_param #(.LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr), .y(y2), .match_cnt(c2), .cnt_sat(s2));
    seq_detect_param #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr), .y(y3), .match_cnt(c3), .cnt_sat(s3));

    // per-configuration description for the model
    int          len  [4] = '{4, 4, 4, 2};
    logic [31:0] pat  [4] = '{32'hB, 32'hB, 32'h0, 32'h3};
    bit          ovl  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          cmax [4] = '{255, 255, 255, 3};

    // model state: bits received since last reset/discard, count, sticky flag
    int hq   [4][$];
    int mcnt [4];
    bit msat [4];

    typedef struct {
        bit y   [4];
        int cnt [4];
        bit sat [4];
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    function automatic int act_cnt(input int d);
        case (d)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    function automatic bit act_y(input int d);
        case (d)
            0: return y0;
            1: return y1;
            2: return y2;
            default: return y3;
        endcase
    endfunction

    function automatic bit act_sat(input int d);
        case (d)
            0: return s0;
            1: return s1;
            2: return s2;
            default: return s3;
        endcase
    endfunction

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d want %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            hq[d].delete();
            mcnt[d] = 0;
            msat[d] = 1'b0;
        end
    endtask

    // the last len[d] accepted bits, oldest first, must equal the pattern MSB first
    task automatic model_step(input bit e, input bit b, input bit c, output exp_t ex);
        for (int d = 0; d < 4; d++) begin
            bit m;
            m = 1'b0;
            if (e) begin
                hq[d].push_back(int'(b));
                if (hq[d].size() > len[d]) void'(hq[d].pop_front());
                if (hq[d].size() == len[d]) begin
                    m = 1'b1;
                    for (int i = 0; i < len[d]; i++)
                        if (hq[d][i] != int'(pat[d][len[d]-1-i])) m = 1'b0;
                end
                if (m && !ovl[d]) hq[d].delete();
            end
            if (c) begin
                mcnt[d] = 0;
                msat[d] = 1'b0;
            end else if (m && mcnt[d] < cmax[d]) begin
                mcnt[d]++;
                msat[d] = (mcnt[d] == cmax[d]);
            end
            ex.y[d]   = m;
            ex.cnt[d] = mcnt[d];
            ex.sat[d] = msat[d];
        end
    endtask

    task automatic cycle(input bit e, input bit b, input bit c);
        exp_t ex;
        @(negedge clk);
        en = e; x = b; cnt_clr = c;
        @(posedge clk);
        model_step(e, b, c, ex);
        sbq.push_back(ex);
    endtask

    // reset lands between edges; outputs must drop without waiting for a clock
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("async_rst_y", d, int'(act_y(d)), 0);
            chk("async_rst_cnt", d, act_cnt(d), 0);
            chk("async_rst_sat", d, int'(act_sat(d)), 0);
        end
        model_reset();
        en = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic stream(input int n, input logic [31:0] bits);
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t ex;
            ex = sbq.pop_front();
            for (int d = 0; d < 4; d++) begin
                chk("y", d, int'(act_y(d)), int'(ex.y[d]));
                chk("match_cnt", d, act_cnt(d), ex.cnt[d]);
                chk("cnt_sat", d, int'(act_sat(d)), int'(ex.sat[d]));
            end
        end
    end

    initial begin
        model_reset();
        #12;
        for (int d = 0; d < 4; d++) begin
            chk("reset_y", d, int'(act_y(d)), 0);
            chk("reset_cnt", d, act_cnt(d), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 1011011: overlap gives two matches, non-overlap one
        stream(7, 32'b1011011);
        #1;
        chk("ovl_cnt", 0, int'(c0), 2);
        chk("novl_cnt", 1, int'(c1), 1);

        // all-zero pattern: no match until four real zeros
        async_reset();
        stream(3, 32'b000);
        #1 chk("zero3_y", 2, int'(y2), 0);
        stream(1, 32'b0);
        #1 chk("zero4_y", 2, int'(y2), 1);
        stream(1, 32'b0);
        #1 chk("zero5_y", 2, int'(y2), 1);

        // en gating: disabled samples are ignored
        async_reset();
        stream(2, 32'b10);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        stream(1, 32'b1);
        #1 chk("en_gap_y", 0, int'(y0), 0);
        stream(1, 32'b1);
        #1 chk("en_done_y", 0, int'(y0), 1);
        chk("en_done_cnt", 0, int'(c0), 1);

        // saturation on the 2-bit counter, then clear on a matching edge
        async_reset();
        stream(6, 32'b111111);
        #1;
        chk("sat_cnt", 3, int'(c3), 3);
        chk("sat_flag", 3, int'(s3), 1);
        cycle(1'b1, 1'b1, 1'b1);
        #1;
        chk("clr_y", 3, int'(y3), 1);
        chk("clr_cnt", 3, int'(c3), 0);
        chk("clr_sat", 3, int'(s3), 0);

        // reset mid-sequence discards partial history
        async_reset();
        stream(7, 32'b1011011);
        stream(3, 32'b101);
        async_reset();
        stream(1, 32'b1);
        #1 chk("post_rst_y", 0, int'(y0), 0);
        stream(4, 32'b1011);
        #1 chk("post_rst_match", 0, int'(y0), 1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 399) async_reset();
            cycle($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 59) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
